hwt_seq_trigger: RTL and testbench

- Parametrised, sequentially triggered hardware-trojan benchmark.
- Computes a registered per-channel golden function y = D & ((A & B) | C) over CHANNELS 4-bit input groups.
- Hides a counter-based trigger FSM that watches channel 0 for a rare pattern. After TRIG_COUNT hits, a payload corrupts the outputs.
- Active counterpart of the passive trojan-free logic cone; used as the device-under-test for trojan-detection experiments.

---
 rtl/hwt_pkg.sv | 27 ++
 rtl/hwt_trigger_fsm.sv | 101 ++++++++++
 rtl/hwt_seq_trigger.sv | 73 +++++++
 tb/tb_hwt_seq_trigger.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hwt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hwt_pkg                                                    |
// | Brief   : Shared types, constants and golden function for the        |
// |           sequentially triggered trojan benchmark.                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package hwt_pkg;

  // Trigger FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2
  } state_e;

  // Payload corruption styles
  localparam int PAYLOAD_INV  = 0;
  localparam int PAYLOAD_ZERO = 1;

  // Clean per-channel function; nibble is {D,C,B,A}
  function automatic logic golden4(input logic [3:0] x);
    return x[3] & ((x[0] & x[1]) | x[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hwt_trigger_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hwt_trigger_fsm                                            |
// | Brief   : Hit counter, IDLE/ARMED/TRIG state machine and optional    |
// |           payload duration timer.                                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module hwt_trigger_fsm
  import hwt_pkg::*;
#(
  parameter logic [3:0] TRIG_PATTERN   = 4'b0110,
  parameter int         TRIG_COUNT     = 8,
  parameter int         CONSECUTIVE    = 1,
  parameter int         PAYLOAD_CYCLES = 0,
  localparam int        CW             = $clog2(TRIG_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [3:0]    pat_i,
  output logic          payload_active_o,
  output logic          triggered_o,
  output logic [CW-1:0] hit_count_o
);

  // Timer only needs to reach PAYLOAD_CYCLES-1; keep one bit when unused
  localparam int TW = (PAYLOAD_CYCLES > 0) ? $clog2(PAYLOAD_CYCLES + 1) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          w_hit;
  logic [CW-1:0] w_cnt_inc;

  assign w_hit     = en_i && (pat_i == TRIG_PATTERN);
  assign w_cnt_inc = cnt_q + CW'(1);

  // State, counter and timer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic: count hits, fire at TRIG_COUNT, optionally time out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (w_hit) begin
          cnt_d   = CW'(1);
          timer_d = '0;
          state_d = (TRIG_COUNT == 1) ? ST_TRIG : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_hit) begin
          cnt_d   = w_cnt_inc;
          timer_d = '0;
          if (w_cnt_inc == CW'(TRIG_COUNT)) begin
            state_d = ST_TRIG;
          end
        end else if (en_i && (CONSECUTIVE != 0)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_TRIG: begin
        cnt_d = CW'(TRIG_COUNT);
        if (PAYLOAD_CYCLES > 0) begin
          if (timer_q == TW'(PAYLOAD_CYCLES - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  assign payload_active_o = (state_q == ST_TRIG);
  assign triggered_o      = (state_q == ST_TRIG);
  assign hit_count_o      = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hwt_seq_trigger.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hwt_seq_trigger                                            |
// | Brief   : Registered golden function over CHANNELS nibbles with a    |
// |           hidden counter-triggered payload that corrupts the output. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module hwt_seq_trigger
  import hwt_pkg::*;
#(
  parameter int         CHANNELS       = 1,
  parameter logic [3:0] TRIG_PATTERN   = 4'b0110,
  parameter int         TRIG_COUNT     = 8,
  parameter int         CONSECUTIVE    = 1,
  parameter int         PAYLOAD_MODE   = 0,
  parameter int         PAYLOAD_CYCLES = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [4*CHANNELS-1:0]              din,
  output logic [CHANNELS-1:0]                dout,
  output logic                               triggered,
  output logic [$clog2(TRIG_COUNT+1)-1:0]    hit_count
);

  logic                w_payload;
  logic [CHANNELS-1:0] w_gold;
  logic [CHANNELS-1:0] dout_d;
  logic [CHANNELS-1:0] dout_q;

  hwt_trigger_fsm #(
    .TRIG_PATTERN   (TRIG_PATTERN),
    .TRIG_COUNT     (TRIG_COUNT),
    .CONSECUTIVE    (CONSECUTIVE),
    .PAYLOAD_CYCLES (PAYLOAD_CYCLES)
  ) u_fsm (
    .clk              (clk),
    .rst              (rst),
    .en_i             (en),
    .pat_i            (din[3:0]),
    .payload_active_o (w_payload),
    .triggered_o      (triggered),
    .hit_count_o      (hit_count)
  );

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign w_gold[k] = golden4(din[4*k +: 4]);
    end
  endgenerate

  // Payload selects the corrupted form based on the pre-edge FSM state
  always_comb begin
    dout_d = w_gold;
    if (w_payload) begin
      dout_d = (PAYLOAD_MODE == PAYLOAD_INV) ? ~w_gold : '0;
    end
  end

  // Output register; no combinational path from din to dout
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_hwt_seq_trigger.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_hwt_seq_trigger                                         |
// | Brief   : Scoreboard bench for three configurations of the trojan    |
// |           benchmark driven by shared directed and random stimulus.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_hwt_seq_trigger;
  import hwt_pkg::*;

  typedef struct {
    logic [1:0] dout;
    logic       trig;
    logic [3:0] cnt;
  } exp_t;

  // Per-configuration settings: 0 default, 1 accumulating, 2 timed zero payload
  localparam int P_CONS [3] = '{1, 0, 1};
  localparam int P_PC   [3] = '{0, 0, 3};
  localparam int P_MODE [3] = '{0, 0, 1};
  localparam int P_CH   [3] = '{1, 1, 2};
  localparam int TC         = 8;
  localparam logic [3:0] PAT = 4'b0110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] din = 8'h00;

  logic       dout0, dout1;
  logic [1:0] dout2;
  logic       trig0, trig1, trig2;
  logic [3:0] hc0, hc1, hc2;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Reference model state: hits so far, firing flag, payload cycles left
  int m_cnt   [3];
  bit m_trig  [3];
  int m_tleft [3];

  always #5 clk = ~clk;

  hwt_seq_trigger u_dut0 (
    .clk(clk), .rst(rst), .en(en), .din(din[3:0]),
    .dout(dout0), .triggered(trig0), .hit_count(hc0)
  );

  hwt_seq_trigger #(.CONSECUTIVE(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .din(din[3:0]),
    .dout(dout1), .triggered(trig1), .hit_count(hc1)
  );

  hwt_seq_trigger #(.CHANNELS(2), .PAYLOAD_MODE(1), .PAYLOAD_CYCLES(3)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout2), .triggered(trig2), .hit_count(hc2)
  );

  // Expected outputs after one clock edge with the given inputs
  function automatic exp_t mstep(input int m, input logic r, input logic e,
                                 input logic [7:0] d);
    exp_t x;
    logic g;
    logic [3:0] nib;
    x.dout = 2'b00;
    if (r) begin
      m_cnt[m]   = 0;
      m_trig[m]  = 1'b0;
      m_tleft[m] = 0;
    end else begin
      for (int ch = 0; ch < P_CH[m]; ch++) begin
        nib = d[4*ch +: 4];
        g   = golden4(nib);
        if (m_trig[m]) g = (P_MODE[m] == 0) ? ~g : 1'b0;
        x.dout[ch] = g;
      end
      if (m_trig[m]) begin
        if (P_PC[m] > 0) begin
          m_tleft[m] = m_tleft[m] - 1;
          if (m_tleft[m] == 0) begin
            m_trig[m] = 1'b0;
            m_cnt[m]  = 0;
          end
        end
      end else if (e && d[3:0] == PAT) begin
        m_cnt[m] = m_cnt[m] + 1;
        if (m_cnt[m] == TC) begin
          m_trig[m]  = 1'b1;
          m_tleft[m] = P_PC[m];
        end
      end else if (e && P_CONS[m] != 0) begin
        m_cnt[m] = 0;
      end
    end
    x.trig = m_trig[m];
    x.cnt  = 4'(m_cnt[m]);
    return x;
  endfunction

  task automatic cyc(input logic r, input logic e, input logic [7:0] d);
    rst = r;
    en  = e;
    din = d;
    @(posedge clk);
    q0.push_back(mstep(0, r, e, d));
    q1.push_back(mstep(1, r, e, d));
    q2.push_back(mstep(2, r, e, d));
    #1;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, {4'h0, PAT});
  endtask

  task automatic check(input string name, input logic [1:0] gd, input logic gt,
                       input logic [3:0] gc, input exp_t x);
    total++;
    if (gd !== x.dout || gt !== x.trig || gc !== x.cnt) begin
      bad++;
      $display("FAIL %s t=%0t got dout=%b trig=%b hit=%0d want dout=%b trig=%b hit=%0d",
               name, $time, gd, gt, gc, x.dout, x.trig, x.cnt);
    end
  endtask

  // Monitor: every edge presents a result; pop and compare mid-cycle
  always @(negedge clk) begin
    exp_t x;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      check("cfg0", {1'b0, dout0}, trig0, hc0, x);
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      check("cfg1", {1'b0, dout1}, trig1, hc1, x);
    end
    if (q2.size() > 0) begin
      x = q2.pop_front();
      check("cfg2", dout2, trig2, hc2, x);
    end
  end

  initial begin
    for (int m = 0; m < 3; m++) begin
      m_cnt[m] = 0; m_trig[m] = 1'b0; m_tleft[m] = 0;
    end
    // Reset and plain golden function with en low
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'hAB);
    cyc(1'b0, 1'b0, 8'h35);
    cyc(1'b0, 1'b0, 8'hC4);
    // Fire on 8 consecutive hits, then observe payload
    hits(8);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'hBB);
    // Reset in the middle of a payload, then clean outputs
    cyc(1'b1, 1'b1, {4'h0, PAT});
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h9B);
    // Break a run of hits with one enabled non-hit
    hits(5);
    cyc(1'b0, 1'b1, 8'h00);
    hits(7);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'hFE);
    // en gating holds the count across a gap
    cyc(1'b1, 1'b0, 8'h00);
    hits(4);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'h00);
    hits(4);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'h7D);
    cyc(1'b1, 1'b0, 8'h00);
    // Randomized traffic with hit bursts and occasional resets
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) hits($urandom_range(6, 10));
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
        logic [7:0] d;
        d = 8'($urandom);
        if ($urandom_range(0, 1) == 1) d[3:0] = PAT;
        cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, d);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0",
               q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
